// File: rtl/hazard_pkg.sv
// hazard_pkg: shared select encodings and tag-slot type for the EXE hazard controller
// Contents: TAG_W (register tag width), SEL_* forwarding select codes, tag_slot_t
//           (one pipeline stage's destination tag: valid, wb_en, mem_r, dest).
package hazard_pkg;
    localparam int TAG_W = 4;
    localparam logic [1:0] SEL_REG     = 2'd0;
    localparam logic [1:0] SEL_ALU_MEM = 2'd1;
    localparam logic [1:0] SEL_WB      = 2'd2;
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r;
        logic [TAG_W-1:0] dest;
    } tag_slot_t;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: compares one ID source register against one pipeline tag slot
// Ports: valid_i/wb_en_i/dest_i  slot fields
//        src_i                   source register number
//        en_i                    source is actually read
//        hit_o                   slot will write the register this source reads
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic             valid_i,
    input  logic             wb_en_i,
    input  logic [TAG_W-1:0] dest_i,
    input  logic [TAG_W-1:0] src_i,
    input  logic             en_i,
    output logic             hit_o
);
    assign hit_o = en_i & valid_i & wb_en_i & (dest_i == src_i);
endmodule

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: EXE-stage forwarding select, load-use stall and memory-wait freeze control
// Ports: clk, rst (async, active-high)
//        id_*_i         instruction currently in ID
//        flush_i        squash the ID instruction (branch taken in EXE)
//        mem_ready_i    data memory finished; mem_busy_i MEM stage is a memory access
//        sel_src1_o/2_o registered EXE operand selects (SEL_REG/SEL_ALU_MEM/SEL_WB)
//        stall_front_o  hold PC and IF/ID; bubble_o insert NOP into ID/EXE
//        freeze_back_o  hold ID/EXE, EXE/MEM, MEM/WB
// Build option: EXE_HAZARD_FORWARDING_EN enables forwarding; without it every
// EXE/MEM dependency stalls and the selects are tied to SEL_REG.
// The WB slot is not stored: the register file writes in the first half-cycle,
// so an instruction in WB never affects a select or a stall.
module exe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid_i,
    input  logic [$clog2(NREG)-1:0] id_src1_i,
    input  logic [$clog2(NREG)-1:0] id_src2_i,
    input  logic                    id_two_src_i,
    input  logic                    id_wb_en_i,
    input  logic                    id_mem_r_en_i,
    input  logic [$clog2(NREG)-1:0] id_dest_i,
    input  logic                    flush_i,
    input  logic                    mem_ready_i,
    input  logic                    mem_busy_i,
    output logic [1:0]              sel_src1_o,
    output logic [1:0]              sel_src2_o,
    output logic                    stall_front_o,
    output logic                    bubble_o,
    output logic                    freeze_back_o
);
    tag_slot_t exe_q, mem_q, exe_d;
    logic flush_pend_q, flush_eff, hazard, enter;
    logic h1e, h2e, h1m, h2m;
    logic [TAG_W-1:0] src1, src2;
    assign src1 = TAG_W'(id_src1_i);
    assign src2 = TAG_W'(id_src2_i);
    hazard_cmp u_c1e (.valid_i(exe_q.valid), .wb_en_i(exe_q.wb_en), .dest_i(exe_q.dest), .src_i(src1), .en_i(1'b1),         .hit_o(h1e));
    hazard_cmp u_c2e (.valid_i(exe_q.valid), .wb_en_i(exe_q.wb_en), .dest_i(exe_q.dest), .src_i(src2), .en_i(id_two_src_i), .hit_o(h2e));
    hazard_cmp u_c1m (.valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en), .dest_i(mem_q.dest), .src_i(src1), .en_i(1'b1),         .hit_o(h1m));
    hazard_cmp u_c2m (.valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en), .dest_i(mem_q.dest), .src_i(src2), .en_i(id_two_src_i), .hit_o(h2m));
    assign freeze_back_o = mem_busy_i & ~mem_ready_i;
    // a flush seen during a freeze squashes the ID instruction at the next advance
    assign flush_eff = flush_i | flush_pend_q;
`ifdef EXE_HAZARD_FORWARDING_EN
    assign hazard = id_valid_i & ~flush_eff & exe_q.mem_r & (h1e | h2e);
`else
    assign hazard = id_valid_i & ~flush_eff & (h1e | h2e | h1m | h2m);
`endif
    assign stall_front_o = freeze_back_o | hazard;
    assign bubble_o      = ~freeze_back_o & hazard;
    assign enter         = id_valid_i & ~flush_eff & ~hazard;
    assign exe_d = enter ? tag_slot_t'{valid: 1'b1, wb_en: id_wb_en_i, mem_r: id_mem_r_en_i, dest: TAG_W'(id_dest_i)}
                         : tag_slot_t'('0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q        <= '0;
            mem_q        <= '0;
            flush_pend_q <= 1'b0;
        end else if (freeze_back_o) begin
            flush_pend_q <= flush_pend_q | flush_i;
        end else begin
            exe_q        <= exe_d;
            mem_q        <= exe_q;
            flush_pend_q <= 1'b0;
        end
    end
`ifdef EXE_HAZARD_FORWARDING_EN
    logic [1:0] sel1_q, sel2_q, sel1_d, sel2_d;
    logic       unused_ld;
    // EXE hit means the producer is in MEM next cycle; the younger producer wins
    assign sel1_d = !enter ? SEL_REG : h1e ? SEL_ALU_MEM : h1m ? SEL_WB : SEL_REG;
    assign sel2_d = !enter ? SEL_REG : h2e ? SEL_ALU_MEM : h2m ? SEL_WB : SEL_REG;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel1_q <= SEL_REG;
            sel2_q <= SEL_REG;
        end else if (!freeze_back_o) begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
        end
    end
    assign sel_src1_o = sel1_q;
    assign sel_src2_o = sel2_q;
    assign unused_ld  = mem_q.mem_r;
`else
    logic unused_ld;
    assign sel_src1_o = SEL_REG;
    assign sel_src2_o = SEL_REG;
    assign unused_ld  = ^{mem_q.mem_r, exe_q.mem_r, id_mem_r_en_i};
`endif
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb_exe_hazard_ctrl: directed and randomized checks of exe_hazard_ctrl against a stage-occupancy model
module tb_exe_hazard_ctrl;
`ifdef EXE_HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_two_src, id_wb_en, id_mem_r_en, flush, mem_ready, mem_busy;
    logic [3:0] id_src1, id_src2, id_dest;
    logic [1:0] sel_src1, sel_src2;
    logic stall_front, bubble, freeze_back;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_hazard_ctrl #(.NREG(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_src1_i(id_src1), .id_src2_i(id_src2), .id_two_src_i(id_two_src),
        .id_wb_en_i(id_wb_en), .id_mem_r_en_i(id_mem_r_en), .id_dest_i(id_dest),
        .flush_i(flush), .mem_ready_i(mem_ready), .mem_busy_i(mem_busy),
        .sel_src1_o(sel_src1), .sel_src2_o(sel_src2),
        .stall_front_o(stall_front), .bubble_o(bubble), .freeze_back_o(freeze_back)
    );

    // model: which instruction occupies EXE and MEM, and what it writes
    typedef struct {bit v; bit wb; bit ld; int d;} ins_t;
    ins_t m_exe, m_mem;
    bit m_fp;
    int m_s1, m_s2;
    bit e_stall, e_bubble, e_freeze, e_enter;

    function automatic bit writes(ins_t s, int r);
        return s.v && s.wb && s.d == r;
    endfunction

    task automatic model_reset;
        m_exe = '{0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0};
        m_fp = 0;
        m_s1 = 0;
        m_s2 = 0;
    endtask

    task automatic model_eval;
        bit fl, de, dm, hz;
        fl = flush || m_fp;
        de = writes(m_exe, int'(id_src1)) || (id_two_src && writes(m_exe, int'(id_src2)));
        dm = writes(m_mem, int'(id_src1)) || (id_two_src && writes(m_mem, int'(id_src2)));
        hz = id_valid && !fl && (FWD ? (de && m_exe.ld) : (de || dm));
        e_freeze = mem_busy && !mem_ready;
        e_stall = e_freeze || hz;
        e_bubble = !e_freeze && hz;
        e_enter = id_valid && !fl && !hz;
    endtask

    task automatic tick;
        model_eval;
        @(posedge clk);
        if (rst) model_reset;
        else if (e_freeze) m_fp = m_fp || flush;
        else begin
            m_s1 = (!FWD || !e_enter) ? 0 : writes(m_exe, int'(id_src1)) ? 1 : writes(m_mem, int'(id_src1)) ? 2 : 0;
            m_s2 = (!FWD || !e_enter || !id_two_src) ? 0 : writes(m_exe, int'(id_src2)) ? 1 : writes(m_mem, int'(id_src2)) ? 2 : 0;
            m_mem = m_exe;
            m_exe = e_enter ? '{1'b1, id_wb_en, id_mem_r_en, int'(id_dest)} : '{0, 0, 0, 0};
            m_fp = 0;
        end
        #1;
    endtask

    task automatic set_id(bit v, int s1, int s2, bit two, bit wb, bit ld, int d);
        id_valid = v;
        id_src1 = 4'(s1);
        id_src2 = 4'(s2);
        id_two_src = two;
        id_wb_en = wb;
        id_mem_r_en = ld;
        id_dest = 4'(d);
    endtask

    task automatic idle;
        set_id(0, 0, 0, 0, 0, 0, 0);
        flush = 0;
        mem_busy = 0;
        mem_ready = 1;
        tick;
        tick;
    endtask

    task automatic test_reset;
        set_id(0, 0, 0, 0, 0, 0, 0);
        flush = 0;
        mem_busy = 0;
        mem_ready = 1;
        rst = 1;
        model_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL reset_sel1 got %0d want 0", sel_src1); end
        checks++; if (sel_src2 !== 2'd0) begin errors++; $display("FAIL reset_sel2 got %0d want 0", sel_src2); end
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_front); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble); end
        checks++; if (freeze_back !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b want 0", freeze_back); end
        #2;
        rst = 0;
        tick;
    endtask

`ifdef EXE_HAZARD_FORWARDING_EN
    task automatic test_fwd_alu;
        idle;
        set_id(1, 0, 0, 0, 1, 0, 1);
        tick;
        set_id(1, 1, 3, 1, 1, 0, 2);
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall_front); end
        tick;
        checks++; if (sel_src1 !== 2'd1) begin errors++; $display("FAIL alu_sel1 got %0d want 1", sel_src1); end
        checks++; if (sel_src2 !== 2'd0) begin errors++; $display("FAIL alu_sel2 got %0d want 0", sel_src2); end
    endtask

    task automatic test_fwd_wb;
        idle;
        set_id(1, 0, 0, 0, 1, 0, 1);
        tick;
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick;
        set_id(1, 5, 1, 1, 1, 0, 4);
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL wb_stall got %b want 0", stall_front); end
        tick;
        checks++; if (sel_src2 !== 2'd2) begin errors++; $display("FAIL wb_sel2 got %0d want 2", sel_src2); end
        checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL wb_sel1 got %0d want 0", sel_src1); end
    endtask

    task automatic test_load_use;
        idle;
        set_id(1, 0, 0, 0, 1, 1, 1);
        tick;
        set_id(1, 1, 1, 1, 1, 0, 2);
        #1;
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL ld_stall got %b want 1", stall_front); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL ld_bubble got %b want 1", bubble); end
        tick;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL ld_stall2 got %b want 0", stall_front); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL ld_bubble2 got %b want 0", bubble); end
        tick;
        checks++; if (sel_src1 !== 2'd2) begin errors++; $display("FAIL ld_sel1 got %0d want 2", sel_src1); end
        checks++; if (sel_src2 !== 2'd2) begin errors++; $display("FAIL ld_sel2 got %0d want 2", sel_src2); end
    endtask
`else
    task automatic test_no_fwd;
        int stalls;
        idle;
        set_id(1, 0, 0, 0, 1, 0, 1);
        tick;
        set_id(1, 1, 3, 1, 1, 0, 2);
        #1;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            if (stall_front) stalls++;
            checks++; if (bubble !== stall_front) begin errors++; $display("FAIL nofwd_bubble cyc %0d got %b want %b", i, bubble, stall_front); end
            tick;
            checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL nofwd_sel1 cyc %0d got %0d want 0", i, sel_src1); end
        end
        checks++; if (stalls != 2) begin errors++; $display("FAIL nofwd_stalls got %0d want 2", stalls); end
    endtask
`endif

    task automatic test_freeze;
        bit entered;
        int exp1, exp2;
        idle;
        set_id(1, 0, 0, 0, 1, 0, 1);
        tick;
        set_id(1, 1, 3, 1, 1, 0, 2);
        entered = 0;
        for (int i = 0; i < 4 && !entered; i++) begin
            model_eval;
            entered = e_enter;
            tick;
        end
        exp1 = m_s1;
        exp2 = m_s2;
        set_id(1, 7, 8, 1, 1, 0, 9);
        mem_busy = 1;
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (freeze_back !== 1'b1) begin errors++; $display("FAIL frz_freeze cyc %0d got %b want 1", i, freeze_back); end
            checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL frz_stall cyc %0d got %b want 1", i, stall_front); end
            checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL frz_bubble cyc %0d got %b want 0", i, bubble); end
            tick;
            checks++; if (sel_src1 !== 2'(exp1)) begin errors++; $display("FAIL frz_sel1 cyc %0d got %0d want %0d", i, sel_src1, exp1); end
            checks++; if (sel_src2 !== 2'(exp2)) begin errors++; $display("FAIL frz_sel2 cyc %0d got %0d want %0d", i, sel_src2, exp2); end
        end
        mem_ready = 1;
        #1;
        checks++; if (freeze_back !== 1'b0) begin errors++; $display("FAIL frz_release got %b want 0", freeze_back); end
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL frz_release_stall got %b want 0", stall_front); end
        tick;
        checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL frz_adv_sel1 got %0d want 0", sel_src1); end
        mem_busy = 0;
    endtask

    task automatic test_flush_freeze;
        idle;
        set_id(1, 0, 0, 0, 1, 0, 9);
        mem_busy = 1;
        mem_ready = 0;
        flush = 1;
        #1;
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL ff_stall got %b want 1", stall_front); end
        tick;
        flush = 0;
        tick;
        mem_ready = 1;
        tick;
        mem_busy = 0;
        set_id(1, 9, 0, 0, 1, 0, 2);
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL ff_dropped_stall got %b want 0", stall_front); end
        tick;
        checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL ff_dropped_sel1 got %0d want 0", sel_src1); end
        set_id(1, 2, 0, 0, 1, 0, 3);
        #1;
        model_eval;
        checks++; if (stall_front !== e_stall) begin errors++; $display("FAIL ff_pend_clear_stall got %b want %b", stall_front, e_stall); end
        tick;
        checks++; if (sel_src1 !== 2'(m_s1)) begin errors++; $display("FAIL ff_pend_clear_sel1 got %0d want %0d", sel_src1, m_s1); end
    endtask

    task automatic test_reset_mid;
        bit entered;
        idle;
        set_id(1, 0, 0, 0, 1, 0, 1);
        tick;
        set_id(1, 1, 0, 0, 1, 1, 3);
        entered = 0;
        for (int i = 0; i < 4 && !entered; i++) begin
            model_eval;
            entered = e_enter;
            tick;
        end
        set_id(1, 3, 0, 0, 1, 0, 4);
        mem_busy = 1;
        mem_ready = 0;
        flush = 1;
        #1;
        checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL rm_pre_stall got %b want 1", stall_front); end
        flush = 0;
        #1;
        rst = 1;
        model_reset;
        #1;
        checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL rm_sel1 got %0d want 0", sel_src1); end
        checks++; if (sel_src2 !== 2'd0) begin errors++; $display("FAIL rm_sel2 got %0d want 0", sel_src2); end
        mem_busy = 0;
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL rm_slots_stall got %b want 0", stall_front); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rm_slots_bubble got %b want 0", bubble); end
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL rm_first_stall got %b want 0", stall_front); end
        tick;
        checks++; if (sel_src1 !== 2'd0) begin errors++; $display("FAIL rm_enter_sel1 got %0d want 0", sel_src1); end
        set_id(1, 4, 0, 0, 1, 0, 5);
        #1;
        model_eval;
        checks++; if (stall_front !== e_stall) begin errors++; $display("FAIL rm_dep_stall got %b want %b", stall_front, e_stall); end
        tick;
        checks++; if (sel_src1 !== 2'(m_s1)) begin errors++; $display("FAIL rm_dep_sel1 got %0d want %0d", sel_src1, m_s1); end
    endtask

    task automatic test_random;
        idle;
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
            flush = $urandom_range(0, 9) == 0;
            mem_busy = $urandom_range(0, 1) != 0;
            mem_ready = $urandom_range(0, 3) != 0;
            #1;
            model_eval;
            checks++; if (stall_front !== e_stall) begin errors++; $display("FAIL rnd_stall i=%0d got %b want %b", i, stall_front, e_stall); end
            checks++; if (bubble !== e_bubble) begin errors++; $display("FAIL rnd_bubble i=%0d got %b want %b", i, bubble, e_bubble); end
            checks++; if (freeze_back !== e_freeze) begin errors++; $display("FAIL rnd_freeze i=%0d got %b want %b", i, freeze_back, e_freeze); end
            tick;
            checks++; if (sel_src1 !== 2'(m_s1)) begin errors++; $display("FAIL rnd_sel1 i=%0d got %0d want %0d", i, sel_src1, m_s1); end
            checks++; if (sel_src2 !== 2'(m_s2)) begin errors++; $display("FAIL rnd_sel2 i=%0d got %0d want %0d", i, sel_src2, m_s2); end
        end
    endtask

    initial begin
        test_reset;
`ifdef EXE_HAZARD_FORWARDING_EN
        test_fwd_alu;
        test_fwd_wb;
        test_load_use;
`else
        test_no_fwd;
`endif
        test_freeze;
        test_flush_freeze;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exe_hazard_ctrl.md
# exe_hazard_ctrl

Pipeline hazard and forwarding controller for the five-stage core. It tracks destination tags of the instructions in EXE, MEM and WB and registers the forwarding selects the EXE stage uses for its operands. It also raises stall and bubble controls for load-use hazards and freezes the back end while the data memory reports not-ready. It sits beside the ID/EXE pipeline register and drives the EXE-stage source muxes, the IF/ID freeze and the ID/EXE bubble insert.

## Interface
- `NREG`, default 16: architectural register count; tag width is clog2(NREG).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_src1`, `id_src2`  in  4  ID source register numbers.
- `id_two_src`  in  1  `id_src2` is really read (register-operand or store).
- `id_wb_en`, `id_mem_r_en`  in  1  ID instruction writes back / is a load.
- `id_dest`  in  4  ID destination register.
- `flush`  in  1  branch taken in EXE; squash the ID instruction.
- `mem_ready`  in  1  data memory finished the MEM-stage access.
- `mem_busy`  in  1  MEM-stage instruction is a memory access.
- `sel_src1`, `sel_src2`  out  2  registered EXE forwarding selects: 0 register value, 1 ALU/MEM value, 2 WB value.
- `stall_front`  out  1  hold PC and IF/ID.
- `bubble`  out  1  load NOP into ID/EXE instead of the ID instruction.
- `freeze_back`  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers.

## Operation
- Three tag slots, EXE, MEM and WB, each holding {valid, wb_en, mem_r, dest}. All slots are invalid after reset.
- Advance, when `freeze_back` is 0:
  - WB takes MEM; MEM takes EXE.
  - EXE takes the ID instruction when `id_valid` is 1, `flush` is 0 and `bubble` is 0; otherwise EXE becomes invalid.
- Hit definitions:
  - A source hits a slot when the slot is valid and wb_en is set and dest equals the source.
  - `id_src2` is compared only when `id_two_src` is 1.
- Load-use hazard: the EXE slot has mem_r set and an ID source hits it.
  - Response: `stall_front` = 1 and `bubble` = 1 for exactly one advancing cycle.
  - On the next cycle the load sits in MEM and the consumer forwards from WB (select 2).
- Select computation, registered on advance and applied to the instruction entering EXE:
  - Hit in the current EXE slot gives 1 (that instruction will be in MEM).
  - Otherwise, hit in the current MEM slot gives 2.
  - Otherwise 0.
  - When both slots hit, EXE (the younger) wins.
- During a bubble or flush, the registered selects are 0.
- `freeze_back` = `mem_busy` & ~`mem_ready`. While it is 1:
  - All slots and selects hold.
  - `stall_front` = 1 and `bubble` = 0.
- `flush` during a freeze is latched in `flush_pend` and applied at the next advance; `flush_pend` clears on that advance.
- `flush` together with a load-use hazard: the flush wins, so no stall is raised and EXE becomes invalid.

## Timing
- Reset values: `sel_src1` = 0, `sel_src2` = 0, `stall_front` = 0, `bubble` = 0, `freeze_back` = 0 while `mem_busy` is 0, `flush_pend` = 0.
- Selects change only on rising edges where the pipeline advances; they are stable for the whole EXE cycle.
- `stall_front`, `bubble` and `freeze_back` are combinational from slot state and inputs in the same cycle, with no added latency.
- Load-use cost: 1 cycle. Memory wait cost: one cycle per cycle `mem_ready` is low.
- Reset asserted mid-operation:
  - Invalidates all slots immediately.
  - Clears selects and `flush_pend`.
  - No stall is asserted on the first cycle after reset.

## Configuration
- `EXE_HAZARD_FORWARDING_EN` defined:
  - Forwarding operates as described.
  - Only load-use hazards stall.
- `EXE_HAZARD_FORWARDING_EN` undefined:
  - `sel_src1` and `sel_src2` are tied to 0.
  - Any hit in the EXE or MEM slot asserts `stall_front` and `bubble` until the hit clears.
  - WB hits do not stall, because the register file writes in the first half-cycle.

## Structure
- Shared package `hazard_pkg`:
  - Select encodings `SEL_REG` = 0, `SEL_ALU_MEM` = 1, `SEL_WB` = 2.
  - Slot struct `tag_slot_t`.
  - `TAG_W` = 4.
- One sub-module, `hazard_cmp`, instantiated per source: combinational compare of one source against a slot, producing the hit flag.

## Test plan
- ADD R1 then SUB R2,R1,R3 back-to-back -> SUB's EXE cycle has `sel_src1` = 1; no stall.
- ADD R1, NOP, then ORR R4,R5,R1 (`id_two_src` = 1) -> `sel_src2` = 2 in ORR's EXE cycle.
- LDR R1 then ADD R2,R1,R1 -> `stall_front` = 1 and `bubble` = 1 for one cycle; ADD then sees `sel_src1` = `sel_src2` = 2.
- STR in MEM with `mem_ready` low for 3 cycles -> `freeze_back` = 1 and `stall_front` = 1 for 3 cycles; selects held; advance on the 4th cycle.
- `flush` pulsed during a freeze -> the ID instruction is dropped at the first advance (EXE slot invalid) and `flush_pend` returns to 0.
- Forwarding macro undefined, ADD R1 then SUB R2,R1,R3 -> 2 stall cycles, `sel_src1` = 0 throughout.
